// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - VGA timing generator and 4x-upscaled RGB332 framebuffer reader
// Owns the framebuffer read port; one-pixel pipeline from counters to DAC outputs.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0]     H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0]     V_LAST     = VW'(V_TOT - 1);
    localparam logic [HW-1:0]     H_VIS      = HW'(H_ACTIVE);
    localparam logic [VW-1:0]     V_VIS      = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     V_LAST_VIS = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0]     HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] FB_STEP    = ADDR_W'(FB_W);

    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] h_word;
    logic              h_wrap, v_wrap, vis, hs_n, vs_n;

    assign h_wrap = (hcnt_q == H_LAST);
    assign v_wrap = (vcnt_q == V_LAST);
    assign vis    = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign hs_n   = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    assign vs_n   = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));

    // Column word is forced to 0 in horizontal blanking so the address never leaves the framebuffer.
    assign h_word  = (hcnt_q < H_VIS) ? ADDR_W'(hcnt_q >> 2) : '0;
    assign fb_addr = line_base_q + h_word;
    assign sync_b  = 1'b0;

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        line_base_d = line_base_q;
        if (pix_en) begin
            if (h_wrap) begin
                hcnt_d = '0;
                if (v_wrap) begin
                    vcnt_d      = '0;
                    line_base_d = '0;
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                    // Every fourth visible line starts the next framebuffer row.
                    if ((vcnt_q[1:0] == 2'd3) && (vcnt_q < V_LAST_VIS)) begin
                        line_base_d = line_base_q + FB_STEP;
                    end
                end
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            line_base_q <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_b     <= 1'b0;
            r           <= 8'h00;
            g           <= 8'h00;
            b           <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            line_base_q <= line_base_d;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hsync   <= hs_n;
                vsync   <= vs_n;
                blank_b <= vis;
                if (vis) begin
                    r <= {fb_data[7:5], fb_data[7:5], fb_data[7:6]};
                    g <= {fb_data[4:2], fb_data[4:2], fb_data[4:3]};
                    b <= {fb_data[1:0], fb_data[1:0], fb_data[1:0], fb_data[1:0]};
                end else begin
                    r <= 8'h00;
                    g <= 8'h00;
                    b <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - self-checking bench for vga_fb_reader on a scaled-down raster
// Position-based reference model, per-cycle compare, plus hand-computed literal pins.
module tb_vga_fb_reader;
    localparam int HA = 32, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 3;
    localparam int FBW = 8, AW = 15;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic          clk = 1'b0;
    logic          rst, pix_en;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          hsync, vsync, sync_b, blank_b, frame_start;
    logic [7:0]    r, g, b;

    vga_fb_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .FB_W(FBW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .fb_addr(fb_addr), .fb_data(fb_data),
        .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
        .r(r), .g(g), .b(b), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM, 1-clk latency; contents are address[7:0] unless overridden.
    logic       ovr = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    always @(posedge clk) fb_data <= ovr ? ovr_val : fb_addr[7:0];

    // Reference model: raster position and what the outputs must show.
    int   mh = 0, mv = 0;
    bit   chk_en = 1'b0, strobed = 1'b0, m_rst = 1'b0;
    logic e_hs, e_vs, e_bl, e_fs;
    logic [7:0] e_r, e_g, e_b;

    always @(posedge clk) begin
        m_rst   <= rst;
        strobed <= 1'b0;
        if (rst) begin
            chk_en <= 1'b1;
            mh <= 0; mv <= 0;
            e_hs <= 1'b1; e_vs <= 1'b1; e_bl <= 1'b0; e_fs <= 1'b0;
            e_r <= 8'h00; e_g <= 8'h00; e_b <= 8'h00;
        end else begin
            e_fs <= pix_en && (mh == HT - 1) && (mv == VT - 1);
            if (pix_en) begin
                strobed <= 1'b1;
                e_hs <= !(mh >= HA + HFP && mh < HA + HFP + HS);
                e_vs <= !(mv >= VA + VFP && mv < VA + VFP + VS);
                e_bl <= (mh < HA) && (mv < VA);
                e_r  <= (mh < HA && mv < VA) ? {fb_data[7:5], fb_data[7:5], fb_data[7:6]} : 8'h00;
                e_g  <= (mh < HA && mv < VA) ? {fb_data[4:2], fb_data[4:2], fb_data[4:3]} : 8'h00;
                e_b  <= (mh < HA && mv < VA) ? {4{fb_data[1:0]}} : 8'h00;
                mh   <= (mh == HT - 1) ? 0 : mh + 1;
                if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
            end
        end
    end

    int hs_run = 0, bl_run = 0, vs_run = 0, fs_gap = 0;
    bit fs_seen = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hsync", hsync, e_hs);
            chk("vsync", vsync, e_vs);
            chk("blank_b", blank_b, e_bl);
            chk("r", r, e_r);
            chk("g", g, e_g);
            chk("b", b, e_b);
            chk("frame_start", frame_start, e_fs);
            chk("sync_b", sync_b, 1'b0);
            chk("fb_addr_range", fb_addr < FBW * (VA / 4), 1'b1);
            if (mh < HA && mv < VA) chk("fb_addr", fb_addr, (mv / 4) * FBW + mh / 4);
            if (m_rst) begin
                hs_run = 0; bl_run = 0; vs_run = 0; fs_seen = 1'b0;
            end else begin
                if (strobed) begin
                    if (!hsync) hs_run++;
                    else if (hs_run > 0) begin chk("hsync_width", hs_run, HS); hs_run = 0; end
                    if (blank_b) bl_run++;
                    else if (bl_run > 0) begin chk("blank_width", bl_run, HA); bl_run = 0; end
                    if (!vsync) vs_run++;
                    else if (vs_run > 0) begin chk("vsync_width", vs_run, VS * HT); vs_run = 0; end
                    if (fs_seen) fs_gap++;
                end
                if (frame_start) begin
                    if (fs_seen) chk("frame_period", fs_gap, HT * VT);
                    fs_seen = 1'b1;
                    fs_gap  = 0;
                end
            end
        end
    end

    int s = 0;
    task automatic at(input int target);
        repeat (target - s) @(posedge clk);
        @(negedge clk);
        s = target;
    endtask

    initial begin
        rst = 1'b1;
        pix_en = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_hsync", hsync, 1'b1);
            chk("rst_vsync", vsync, 1'b1);
            chk("rst_blank", blank_b, 1'b0);
            chk("rst_rgb", {r, g, b}, 24'h0);
            chk("rst_addr", fb_addr, 0);
            chk("rst_fs", frame_start, 1'b0);
        end
        rst = 1'b0;

        at(1);    chk("first_vis", blank_b, 1'b1);
        at(5);    chk("addr_h5", fb_addr, 1);
        at(31);   chk("addr_h31", fb_addr, 7);
        at(32);   chk("blank_last", blank_b, 1'b1);
        at(33);   chk("blank_off", blank_b, 1'b0);
        at(36);   chk("hs_before", hsync, 1'b1);
        at(37);   chk("hs_fall", hsync, 1'b0);
        at(44);   chk("hs_last", hsync, 1'b0);
        at(45);   chk("hs_rise", hsync, 1'b1);
        at(192);  chk("addr_line4", fb_addr, 8);
        at(720);  chk("addr_line15", fb_addr, 24);
        at(864);  chk("vs_before", vsync, 1'b1);
        at(865);  chk("vs_fall", vsync, 1'b0);
        at(960);  chk("vs_last", vsync, 1'b0);
        at(961);  chk("vs_rise", vsync, 1'b1);
        at(1103); chk("fs_before", frame_start, 1'b0);
        at(1104); chk("fs_pulse", frame_start, 1'b1);
        at(1105); chk("fs_after", frame_start, 1'b0);

        ovr = 1'b1; ovr_val = 8'hE0;
        at(1107); chk("red_r", r, 8'hFF); chk("red_g", g, 8'h00); chk("red_b", b, 8'h00);
        ovr_val = 8'h03;
        at(1109); chk("blue_b", b, 8'hFF); chk("blue_r", r, 8'h00); chk("blue_g", g, 8'h00);
        ovr_val = 8'hA9;
        at(1111); chk("mix_r", r, 8'hB6); chk("mix_g", g, 8'h49); chk("mix_b", b, 8'h55);
        ovr = 1'b0;

        for (int i = 0; i < 3600; i++) begin
            pix_en = (i % 3 == 0);
            @(negedge clk);
        end
        pix_en = 1'b1;

        begin
            int guard;
            guard = 0;
            while (!(mh == 20 && mv == 10) && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            chk("midframe_reach", guard < 3000, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_addr", fb_addr, 0);
        chk("mid_rst_fs", frame_start, 1'b0);
        @(negedge clk);
        chk("mid_next_addr", fb_addr, 0);
        chk("mid_next_blank", blank_b, 1'b1);
        chk("mid_next_fs", frame_start, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_addr_h5", fb_addr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
